// File: rtl/dma_word_responder_if.sv
// Signal bundle joining the ECDSA DMA initiator, dma_word_responder and its
// single-port word memory.
interface dma_word_responder_if #(
    parameter int unsigned MEM_WORDS = 4096
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic          dma_rx_start;
    logic [31:0]   dma_rx_address;
    logic [380:0]  dma_rx_data;
    logic          dma_tx_start;
    logic [31:0]   dma_tx_address;
    logic [380:0]  dma_tx_data;
    logic          dma_done;
    logic          dma_idle;
    logic          dma_error;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [31:0]   mem_rdata;
    logic          mem_wr_en;
    logic [31:0]   mem_wdata;

    modport slave (
        input  dma_rx_start, dma_rx_address, dma_tx_start, dma_tx_address,
               dma_tx_data, mem_rdata,
        output dma_rx_data, dma_done, dma_idle, dma_error,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport master (
        output dma_rx_start, dma_rx_address, dma_tx_start, dma_tx_address,
               dma_tx_data, mem_rdata,
        input  dma_rx_data, dma_done, dma_idle, dma_error,
               mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/dma_word_responder.sv
// Memory-side responder splitting 381-bit DMA reads/writes into twelve 32-bit words.
// Define DMA_RESP_BOUNDS_CHECK_EN to reject requests falling outside the memory.
module dma_word_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 resetn,
    dma_word_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [383:0]  frame_q, frame_d;
    logic [380:0]  rx_data_q, rx_data_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;

    logic          acc_rd;
    logic [31:0]   acc_addr;
    logic [31:0]   offset;
    logic          acc_bad;
    logic [3:0]    word_sel;
    logic          unused_offset;

    assign acc_rd        = bus.dma_rx_start;
    assign acc_addr      = acc_rd ? bus.dma_rx_address : bus.dma_tx_address;
    assign offset        = acc_addr - BASE_ADDR;
    assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

`ifdef DMA_RESP_BOUNDS_CHECK_EN
    assign acc_bad = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                     (({2'b00, offset[31:2]} + 32'd11) >= MEM_WORDS);
`else
    assign acc_bad = (acc_addr[1:0] != 2'b00);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        frame_d   = frame_q;
        rx_data_d = rx_data_q;
        err_d     = err_q;
        pend_d    = pend_q;
        unique case (state_q)
            IDLE: begin
                if (bus.dma_rx_start || bus.dma_tx_start) begin
                    err_d  = acc_bad || (bus.dma_rx_start && bus.dma_tx_start);
                    base_d = offset[AW+1:2];
                    cnt_d  = '0;
                    if (acc_bad) begin
                        state_d = DONE;
                        pend_d  = 1'b1;
                    end else if (acc_rd) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                        frame_d = {bus.dma_tx_data, 3'b000};
                    end
                end
            end
            RD: begin
                // read data trails the address by one cycle, so word cnt-1 arrives now
                cnt_d = cnt_q + 4'd1;
                if (cnt_q != 4'd0) frame_d = {frame_q[351:0], bus.mem_rdata};
                if (cnt_q == 4'd12) begin
                    state_d   = DONE;
                    rx_data_d = frame_d[383:3];
                end
            end
            WR: begin
                cnt_d   = cnt_q + 4'd1;
                frame_d = frame_q << 32;
                if (cnt_q == 4'd12) state_d = DONE;
            end
            DONE: begin
                // an error spends one silent cycle here so done lands on E1
                if (pend_q) pend_d  = 1'b0;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            frame_q   <= '0;
            rx_data_q <= '0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            frame_q   <= frame_d;
            rx_data_q <= rx_data_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
        end
    end

    assign word_sel      = (cnt_q > 4'd11) ? 4'd11 : cnt_q;
    assign bus.mem_addr  = base_q + AW'(word_sel);
    assign bus.mem_rd_en = (state_q == RD);
    assign bus.mem_wr_en = (state_q == WR) && (cnt_q != 4'd12);
    assign bus.mem_wdata = frame_q[383:352];
    assign bus.dma_done  = (state_q == DONE) && !pend_q;
    assign bus.dma_idle  = (state_q == IDLE);
    assign bus.dma_error = err_q;
    assign bus.dma_rx_data = rx_data_q;
endmodule
